// File: rtl/echo_client_pkg.sv
// Shared definitions for the echo request/indication protocol: client state
// encoding, the echo payload carried on both say and heard, and size defaults.
package echo_client_pkg;

    // Client FSM state encoding (2 bits, exposed on the debug output).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Payload carried by say requests and heard indications; the echo
    // responder uses the same layout so queue entries compare directly.
    typedef struct packed {
        logic [31:0] meth;
        logic [31:0] v;
    } echo_payload_t;

    localparam int ECHO_PAYLOAD_W    = $bits(echo_payload_t);
    localparam int DEPTH_LOG_DEFAULT = 2;
    localparam int ERR_W_DEFAULT     = 16;

    // True when an indication differs from the request it should echo.
    function automatic logic payload_mismatch(input echo_payload_t got,
                                              input echo_payload_t want);
        return (got.meth != want.meth) || (got.v != want.v);
    endfunction

endpackage

// File: rtl/echo_expect_fifo.sv
// In-order queue of expected payloads. The head is visible combinationally;
// push and pop in the same cycle advance both pointers and keep occupancy.
// A push while full or a pop while empty is ignored, so the producer and
// consumer can gate on full/empty without extra care.
module echo_expect_fifo
    import echo_client_pkg::*;
#(
    parameter int DEPTH_LOG = DEPTH_LOG_DEFAULT,
    parameter int W         = ECHO_PAYLOAD_W
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   occ
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
    localparam logic [DEPTH_LOG:0]   OCC_ONE  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG:0]   OCC_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at 2**DEPTH_LOG; occupancy tracks push - pop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/echo_client.sv
// Echo traffic initiator/checker. A start call programs a burst of say
// requests; every request is remembered in an expected queue and each heard
// indication is compared against the queue head. When every indication is
// back, a done indication reports the received count and mismatch count.
//
// Handshake: every method (start, say, heard, done) transfers in a cycle iff
// its __ENA and __RDY are both high at the posedge. An __ENA seen while the
// matching __RDY is low is dropped, never latched. All __ENA/__RDY outputs of
// this block depend only on registered state.
module echo_client
    import echo_client_pkg::*;
#(
    parameter int DEPTH_LOG = DEPTH_LOG_DEFAULT,
    parameter int ERR_W     = ERR_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [31:0]      start_count,
    input  logic [31:0]      start_meth,
    input  logic [31:0]      start_v,
    output logic             start__RDY,
    output logic             say__ENA,
    output logic [31:0]      say_meth,
    output logic [31:0]      say_v,
    input  logic             say__RDY,
    input  logic             heard__ENA,
    input  logic [31:0]      heard_meth,
    input  logic [31:0]      heard_v,
    output logic             heard__RDY,
    output logic             done__ENA,
    output logic [31:0]      done_count,
    output logic [ERR_W-1:0] done_errors,
    input  logic             done__RDY,
    output logic [1:0]       dbg_state
);

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      count_q;
    logic [31:0]      meth_q;
    logic [31:0]      base_q;
    logic [31:0]      issued;
    logic [31:0]      received;
    logic [31:0]      issued_nxt;
    logic [31:0]      received_nxt;
    logic [ERR_W-1:0] err;

    logic             start_fire;
    logic             say_fire;
    logic             heard_fire;
    logic             done_fire;
    logic             q_full;
    logic             q_empty;
    logic [DEPTH_LOG:0] q_occ;
    echo_payload_t    q_head;
    echo_payload_t    say_payload;
    echo_payload_t    heard_payload;

    // Method enables toward the environment are pure functions of state.
    assign start__RDY = (state == ST_IDLE);
    assign say__ENA   = (state == ST_RUN) && (issued < count_q) && !q_full;
    assign say_meth   = (state == ST_RUN) ? meth_q : '0;
    assign say_v      = (state == ST_RUN) ? (base_q + issued) : '0;
    assign heard__RDY = ((state == ST_RUN) || (state == ST_DRAIN)) && !q_empty;
    assign done__ENA  = (state == ST_DONE);
    assign done_count  = (state == ST_DONE) ? received : '0;
    assign done_errors = (state == ST_DONE) ? err : '0;
    assign dbg_state  = state;

    assign start_fire = start__ENA && start__RDY;
    assign say_fire   = say__ENA && say__RDY;
    assign heard_fire = heard__ENA && heard__RDY;
    assign done_fire  = done__ENA && done__RDY;

    assign issued_nxt   = issued + {31'd0, say_fire};
    assign received_nxt = received + {31'd0, heard_fire};

    assign say_payload   = '{meth: say_meth, v: say_v};
    assign heard_payload = '{meth: heard_meth, v: heard_v};

    echo_expect_fifo #(
        .DEPTH_LOG (DEPTH_LOG),
        .W         (ECHO_PAYLOAD_W)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (say_fire),
        .push_data (say_payload),
        .pop       (heard_fire),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .occ       (q_occ)
    );

    // Next-state selection for the burst sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_fire) begin
                    state_nxt = (start_count == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_nxt == count_q) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (received_nxt == count_q) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (done_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst parameters are captured once per start and held for the burst.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
            meth_q  <= '0;
            base_q  <= '0;
        end else if (start_fire) begin
            count_q <= start_count;
            meth_q  <= start_meth;
            base_q  <= start_v;
        end
    end

    // Issue/receive progress and saturating mismatch counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issued   <= '0;
            received <= '0;
            err      <= '0;
        end else if (start_fire) begin
            issued   <= '0;
            received <= '0;
            err      <= '0;
        end else begin
            issued   <= issued_nxt;
            received <= received_nxt;
            if (heard_fire && payload_mismatch(heard_payload, q_head) && (err != ERR_MAX)) begin
                err <= err + ERR_ONE;
            end
        end
    end

endmodule

// File: doc/echo_client.md
Name: echo_client

Overview:
- Initiator/checker for the echo request/indication protocol: issues a programmed burst of say(meth, v) requests and consumes the returning heard(meth, v) indications.
- Each indication is checked against an in-order expected queue; mismatches are counted.
- A done indication reports results to the controlling software stub.
- Sits at the opposite end of the say/heard channel pair from the echo responder; used as the on-chip traffic source in loopback configurations.

Parameters:
- DEPTH_LOG, 2, log2 of the expected-queue depth (max outstanding requests = 2**DEPTH_LOG).
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- CLK  input  1  clock; all state updates on the posedge.
- nRST  input  1  reset; asynchronous assert, active-low.
- start__ENA  input  1  start-burst method enable.
- start_count  input  32  number of say requests to issue.
- start_meth  input  32  meth value carried by every request in the burst.
- start_v  input  32  base v; request i carries start_v+i (mod 2**32).
- start__RDY  output  1  high only in IDLE.
- say__ENA  output  1  request valid toward responder.
- say_meth  output  32  request meth.
- say_v  output  32  request v.
- say__RDY  input  1  responder ready.
- heard__ENA  input  1  indication valid from responder.
- heard_meth  input  32  indication meth.
- heard_v  input  32  indication v.
- heard__RDY  output  1  client can accept an indication.
- done__ENA  output  1  burst-complete indication valid.
- done_count  output  32  number of indications received in the burst.
- done_errors  output  ERR_W  mismatch count.
- done__RDY  input  1  consumer ready for done.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; issued, received, err, queue pointers and occupancy cleared; all __ENA outputs 0; start__RDY=1; heard__RDY=0; data outputs 0.
- A method fires in a cycle iff its ENA && RDY; ENA with RDY low is ignored (no latching).
- State IDLE:
  - start fires -> latch count/meth/base v, clear issued, received and err.
  - count==0 -> DONE; otherwise -> RUN.
- State RUN:
  - say__ENA = (issued<count) && queue not full.
  - say_meth = latched meth; say_v = base+issued.
  - say fire -> push {say_meth, say_v}, issued+1.
  - When issued==count at the end of a cycle -> DRAIN.
- heard__RDY = (RUN or DRAIN) && queue not empty.
- heard fire -> pop head; received+1; if {heard_meth, heard_v} != head then err+1, saturating at 2**ERR_W-1.
- Push and pop in the same cycle are both legal: occupancy unchanged, pointers both advance.
  - Full queue: push blocked by say__ENA=0.
  - Empty queue: pop blocked by heard__RDY=0.
  - Pointers wrap modulo 2**DEPTH_LOG.
- State DRAIN: no say; queue empty (received==count) -> DONE.
- State DONE:
  - done__ENA=1; done_count=received; done_errors=err, held stable until done__RDY.
  - done fire -> IDLE.
- Latency: first say__ENA in the cycle after start fires; done__ENA the cycle after the last pop.
- Outputs are registered-state functions only; no combinational path from the ENA/RDY inputs to the __RDY outputs, except that say fire and heard fire are qualified by their inputs.
- An indication arriving while heard__RDY=0 is not consumed and is not counted.
- Reset mid-burst aborts immediately: no done is emitted and the queue contents are discarded.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the echo payload struct {meth[31:0], v[31:0]}, shared with the echo responder;
  - the DEPTH_LOG default.
- One sub-module, echo_expect_fifo: a 64-bit wide, 2**DEPTH_LOG deep, same-cycle push/pop FIFO exposing full/empty. Also reusable by other checkers.

Test Plan:
- Loopback to a 1-deep echo responder, start(count=3, meth=7, v=0x10):
  - says carry v=0x10, 0x11, 0x12;
  - done fires with count=3, errors=0.
- start(count=0) -> no say__ENA ever; done__ENA the next cycle with count=0, errors=0; start__RDY low until done is accepted.
- Responder model with say__RDY=1 that withholds heard, start(count=10):
  - exactly 4 says accepted, then say__ENA=0 (queue full);
  - releasing heard resumes issuing; done count=10.
- Corrupting model returning v+1 on the 2nd indication, count=4 -> done_errors=1, done_count=4.
- Same-cycle say fire and heard fire while occupancy=2 -> occupancy stays 2. Run with start_v=0xFFFFFFFE, count=3 -> v sequence FFFFFFFE, FFFFFFFF, 00000000, no errors.
- Assert nRST low asynchronously mid-RUN (no clock edge), then release -> all ENA outputs 0 and start__RDY=1 immediately; the next start(count=2) completes with errors=0.
